// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared types and helpers for the FFT sequencer.
//   fft_seq_state_e : sequencer state encoding (all 8 codes used)
//   bitrev          : reverse the low w bits of v (w <= 32)
package fft_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RD     = 3'd2,
    RWAIT  = 3'd3,
    BF     = 3'd4,
    WR     = 3'd5,
    UNLOAD = 3'd6,
    DONE   = 3'd7
  } fft_seq_state_e;

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w && i < 32; i++) begin
      r[i[4:0]] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// fft_bf_addr_gen: combinational radix-2 DIT butterfly address generator.
//   stage_i  : current stage s
//   k_i      : butterfly index within the stage
//   addr_a_o : top operand address     (grp*2h + pos)
//   addr_b_o : bottom operand address  (addr_a + h)
//   tw_idx_o : twiddle ROM index       (pos << (LOG2N-1-s))
module fft_bf_addr_gen #(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned AW    = LOG2N,
  parameter int unsigned SW    = $clog2(LOG2N + 1)
) (
  input  logic [SW-1:0] stage_i,
  input  logic [AW-2:0] k_i,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o,
  output logic [AW-2:0] tw_idx_o
);

  logic [AW-1:0] k_ext;
  logic [AW-1:0] h;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;
  logic [AW-1:0] a;
  logic [SW-1:0] tw_sh;

  always_comb begin
    k_ext = {1'b0, k_i};
    h     = AW'(1) << stage_i;
    pos   = k_ext & (h - AW'(1));
    grp   = k_ext >> stage_i;
    // pos < h, so OR-ing it under the shifted group equals grp*2h + pos
    a     = (grp << (stage_i + SW'(1))) | pos;
    tw_sh = SW'(LOG2N - 1) - stage_i;
    addr_a_o = a;
    addr_b_o = a + h;
    tw_idx_o = (AW-1)'(pos << tw_sh);
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: N-point radix-2 DIT FFT sequencer (load / compute / unload).
//   clk_i, rst_ni            : clock, async active-low reset
//   start_i                  : frame start, sampled in IDLE only
//   smp_valid_i/smp_ready_o  : sample input handshake; mem_we_o = valid & ready
//   ld_addr_o                : bit-reversed sample write address
//   rd_en_o, addr_a_o/b_o,
//   tw_idx_o, bf_start_o,
//   res_we_o                 : butterfly read / launch / write-back controls
//   out_valid_o/out_ready_i,
//   out_addr_o               : natural-order unload stream
//   busy_o, done_o, state_o  : status
//   abort_i                  : present only when FFT_SEQ_ABORT_EN is defined
module fft_seq_ctrl
  import fft_seq_pkg::*;
#(
  parameter  int unsigned N_POINTS = 16,
  parameter  int unsigned RD_LAT   = 2,
  parameter  int unsigned BF_LAT   = 1,
  localparam int unsigned LOG2N    = $clog2(N_POINTS),
  localparam int unsigned AW       = LOG2N,
  localparam int unsigned SW       = $clog2(LOG2N + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           smp_valid_i,
  output logic           smp_ready_o,
  output logic           mem_we_o,
  output logic [AW-1:0]  ld_addr_o,
  output logic           rd_en_o,
  output logic [AW-1:0]  addr_a_o,
  output logic [AW-1:0]  addr_b_o,
  output logic [AW-2:0]  tw_idx_o,
  output logic           bf_start_o,
  output logic           res_we_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [AW-1:0]  out_addr_o,
  output logic           busy_o,
  output logic           done_o,
  output fft_seq_state_e state_o
`ifdef FFT_SEQ_ABORT_EN
  ,
  input  logic           abort_i
`endif
);

  localparam int unsigned WMAX = (RD_LAT > BF_LAT) ? RD_LAT : BF_LAT;
  localparam int unsigned WW   = $clog2(WMAX + 1);

  localparam logic [AW-1:0] LD_LAST  = AW'(N_POINTS - 1);
  localparam logic [AW-2:0] K_LAST   = (AW-1)'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(LOG2N - 1);
  localparam logic [WW-1:0] RWAIT_LAST = WW'(RD_LAT - 1);
  localparam logic [WW-1:0] BF_LAST    = WW'(BF_LAT - 1);

  fft_seq_state_e state_q, state_d;
  logic [AW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [AW-2:0]  k_q, k_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [AW-1:0]  u_cnt_q, u_cnt_d;

  logic           abort;
  logic [AW-1:0]  gen_a, gen_b;
  logic [AW-2:0]  gen_tw;

  always_comb begin
`ifdef FFT_SEQ_ABORT_EN
    abort = abort_i;
`else
    abort = 1'b0;
`endif
  end

  fft_bf_addr_gen #(
    .LOG2N (LOG2N),
    .AW    (AW),
    .SW    (SW)
  ) u_addr_gen (
    .stage_i  (stage_q),
    .k_i      (k_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      k_q      <= '0;
      stage_q  <= '0;
      wait_q   <= '0;
      u_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      k_q      <= k_d;
      stage_q  <= stage_d;
      wait_q   <= wait_d;
      u_cnt_q  <= u_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    k_d      = k_q;
    stage_d  = stage_q;
    wait_d   = wait_q;
    u_cnt_d  = u_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD;
          ld_cnt_d = '0;
          k_d      = '0;
          stage_d  = '0;
          wait_d   = '0;
          u_cnt_d  = '0;
        end
      end
      LOAD: begin
        if (smp_valid_i) begin
          ld_cnt_d = ld_cnt_q + AW'(1);
          if (ld_cnt_q == LD_LAST) begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = RWAIT;
        wait_d  = '0;
      end
      RWAIT: begin
        if (wait_q == RWAIT_LAST) begin
          state_d = BF;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + WW'(1);
        end
      end
      BF: begin
        if (wait_q == BF_LAST) begin
          state_d = WR;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + WW'(1);
        end
      end
      WR: begin
        state_d = RD;
        if (k_q == K_LAST) begin
          k_d = '0;
          if (stage_q == S_LAST) begin
            state_d = UNLOAD;
            stage_d = '0;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          k_d = k_q + (AW-1)'(1);
        end
      end
      UNLOAD: begin
        if (out_ready_i) begin
          u_cnt_d = u_cnt_q + AW'(1);
          if (u_cnt_q == LD_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // abort overrides every transition computed above
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      ld_cnt_d = '0;
      k_d      = '0;
      stage_d  = '0;
      wait_d   = '0;
      u_cnt_d  = '0;
    end
  end

  logic ld_active;
  logic bf_active;

  always_comb begin
    ld_active   = (state_q == LOAD);
    bf_active   = (state_q == RD) || (state_q == RWAIT) ||
                  (state_q == BF) || (state_q == WR);

    smp_ready_o = ld_active;
    mem_we_o    = smp_valid_i & ld_active;
    ld_addr_o   = ld_active ? AW'(bitrev(32'(ld_cnt_q), AW)) : '0;

    rd_en_o     = (state_q == RD);
    addr_a_o    = bf_active ? gen_a  : '0;
    addr_b_o    = bf_active ? gen_b  : '0;
    tw_idx_o    = bf_active ? gen_tw : '0;
    bf_start_o  = (state_q == BF) && (wait_q == '0);
    res_we_o    = (state_q == WR);

    out_valid_o = (state_q == UNLOAD);
    out_addr_o  = (state_q == UNLOAD) ? u_cnt_q : '0;

    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    state_o     = state_q;
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;
  import fft_seq_pkg::*;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic smp_valid = 1'b0;
  logic out_ready = 1'b1;
`ifdef FFT_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  logic          smp_ready, mem_we, rd_en, bf_start, res_we, out_valid, busy, done;
  logic [AW-1:0] ld_addr, addr_a, addr_b, out_addr;
  logic [AW-2:0] tw_idx;
  fft_seq_state_e state;

  fft_seq_ctrl #(
    .N_POINTS (16),
    .RD_LAT   (2),
    .BF_LAT   (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .smp_valid_i (smp_valid),
    .smp_ready_o (smp_ready),
    .mem_we_o    (mem_we),
    .ld_addr_o   (ld_addr),
    .rd_en_o     (rd_en),
    .addr_a_o    (addr_a),
    .addr_b_o    (addr_b),
    .tw_idx_o    (tw_idx),
    .bf_start_o  (bf_start),
    .res_we_o    (res_we),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_addr_o  (out_addr),
    .busy_o      (busy),
    .done_o      (done),
    .state_o     (state)
`ifdef FFT_SEQ_ABORT_EN
    ,
    .abort_i     (abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
  } bfx_t;

  // bit-reversed load order for 16 points
  int unsigned ld_exp [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] ld_q [$];
  logic [AW-1:0] ua_q [$];
  bfx_t          bf_q [$];
  int            done_pend = 0;
  int            done_total = 0;
  int            comp_cycles = 0;
  int            bfs_cnt = 0;
  int            bf_idx = 0;
  bfx_t          cur_bf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({smp_ready, mem_we, ld_addr, rd_en, addr_a, addr_b, tw_idx,
                 bf_start, res_we, out_valid, out_addr, busy, done});
  endfunction

  // Expected responses of one complete frame, in the textbook DIT loop order.
  task automatic push_frame();
    for (int i = 0; i < 16; i++) ld_q.push_back(AW'(ld_exp[i]));
    for (int s = 0; s < 4; s++) begin
      int h;
      h = 1 << s;
      for (int j = 0; j < 16; j += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          bfx_t e;
          e.a  = 4'(j + p);
          e.b  = 4'(j + p + h);
          e.tw = 3'(p * (8 / h));
          bf_q.push_back(e);
        end
      end
    end
    for (int i = 0; i < 16; i++) ua_q.push_back(AW'(i));
    done_pend++;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (state == RD || state == RWAIT || state == BF || state == WR) comp_cycles++;
      if (bf_start) bfs_cnt++;
      if (smp_ready) bf_idx = 0;

      if (mem_we) begin
        if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
        else chk("ld_addr", int'(ld_addr), int'(ld_q.pop_front()));
      end

      if (rd_en) begin
        if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
        else begin
          cur_bf = bf_q.pop_front();
          chk("bf_a", int'(addr_a), int'(cur_bf.a));
          chk("bf_b", int'(addr_b), int'(cur_bf.b));
          chk("bf_tw", int'(tw_idx), int'(cur_bf.tw));
        end
        case (bf_idx)
          0:  begin chk("s0k0_a", int'(addr_a), 0); chk("s0k0_b", int'(addr_b), 1);  chk("s0k0_tw", int'(tw_idx), 0); end
          13: begin chk("s1k5_a", int'(addr_a), 9); chk("s1k5_b", int'(addr_b), 11); chk("s1k5_tw", int'(tw_idx), 4); end
          31: begin chk("s3k7_a", int'(addr_a), 7); chk("s3k7_b", int'(addr_b), 15); chk("s3k7_tw", int'(tw_idx), 7); end
          default: ;
        endcase
        bf_idx++;
      end

      if (res_we) begin
        chk("wr_a_stable", int'(addr_a), int'(cur_bf.a));
        chk("wr_b_stable", int'(addr_b), int'(cur_bf.b));
        chk("wr_tw_stable", int'(tw_idx), int'(cur_bf.tw));
      end

      if (out_valid && out_ready) begin
        if (ua_q.size() == 0) chk("unload_unexpected", 1, 0);
        else chk("out_addr", int'(out_addr), int'(ua_q.pop_front()));
      end

      if (done) begin
        done_total++;
        if (done_pend == 0) chk("done_unexpected", 1, 0);
        else done_pend--;
      end
    end
  end

  task automatic wait_state(input fft_seq_state_e st, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (state == st) return;
    end
    chk(name, 0, 1);
  endtask

  task automatic wait_out_addr(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (out_valid && int'(out_addr) == n) return;
    end
    chk(name, 0, 1);
  endtask

  task automatic run_frame(input int gap_smp, input int gap_out, input bit start_pulses);
    int c0, b0, d0;
    push_frame();
    c0 = comp_cycles; b0 = bfs_cnt; d0 = done_total;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("load_entry", int'(state), int'(LOAD));
    chk("ld_first", int'(ld_addr), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_smp) begin
        smp_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(posedge clk); #1;
          chk("ld_hold", int'(ld_addr), int'(ld_exp[i]));
        end
      end
      smp_valid = 1'b1;
      @(posedge clk); #1;
    end
    smp_valid = 1'b0;
    if (start_pulses) begin
      wait_state(BF, 50, "wait_bf_timeout");
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
      wait_out_addr(3, 400, "wait_u3_timeout");
      start = 1'b1; @(posedge clk); #1 start = 1'b0;
    end
    if (gap_out >= 0) begin
      wait_out_addr(gap_out, 400, "wait_ugap_timeout");
      out_ready = 1'b0;
      for (int g = 0; g < 3; g++) begin
        @(posedge clk); #1;
        chk("out_hold", int'(out_addr), gap_out);
      end
      out_ready = 1'b1;
    end
    wait_state(DONE, 400, "wait_done_timeout");
    @(posedge clk); #1;
    chk("idle_after_done", int'(state), int'(IDLE));
    chk("done_pulses", done_total - d0, 1);
    chk("compute_cycles", comp_cycles - c0, 160);
    chk("bf_starts", bfs_cnt - b0, 32);
  endtask

  initial begin
    #1;
    chk("reset_state", int'(state), int'(IDLE));
    chk("reset_outputs", all_outs(), 0);
    #11 rst_n = 1'b1;

    // reset asserted in the middle of LOAD
    for (int i = 0; i < 5; i++) ld_q.push_back(AW'(ld_exp[i]));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp_valid = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midload_rst_state", int'(state), int'(IDLE));
    chk("midload_rst_outputs", all_outs(), 0);
    chk("midload_ld_consumed", ld_q.size(), 0);
    smp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_total, 0);

    run_frame(-1, -1, 1'b0);
    run_frame(6, 9, 1'b1);

`ifdef FFT_SEQ_ABORT_EN
    for (int i = 0; i < 5; i++) ld_q.push_back(AW'(ld_exp[i]));
    begin
      int d0;
      d0 = done_total;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        smp_valid = 1'b1;
        @(posedge clk); #1;
      end
      smp_valid = 1'b0;
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_state", int'(state), int'(IDLE));
      chk("abort_outputs", all_outs(), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", done_total - d0, 0);
    end
    run_frame(-1, -1, 1'b0);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("ld_q_empty", ld_q.size(), 0);
    chk("bf_q_empty", bf_q.size(), 0);
    chk("ua_q_empty", ua_q.size(), 0);
    chk("done_pending", done_pend, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
